pwm_dac_out: RTL and testbench
==============================

Name: pwm_dac_out

Overview:
- Output stage that sits directly downstream of the 8-bit sine wave generator and converts its `wave_out` samples into a single-bit PWM stream for an external RC filter or pin.
- Samples `wave_in` once per 256-clock PWM period and applies a digital gain of 0..16/16 around midscale (128).
- Uses a soft-start/soft-stop state machine that ramps the gain one step per period, so enable/disable does not produce audible pops or steps.

Parameters:
- MAX_GAIN, 16, full-scale gain value (unity); gain_target is clamped to this value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; 1 = run output, 0 = fade out then stop
- gain_target  input  5  requested gain, 0..16 (values >16 clamp to 16)
- wave_in  input  8  unsigned sample, midscale 128
- pwm_out  output  1  registered PWM output
- period_tick  output  1  high for the one cycle where cnt==0
- duty  output  8  duty value in use for the current period
- gain_cur  output  5  current gain g
- active  output  1  high when state != OFF

Behaviour:
- Reset (sync, active-high): cnt=0, state=OFF, g=0, duty=0, pwm_out=0, active=0. Reset takes effect at any point, including mid-period and mid-fade.
- Period counter:
  - cnt is 8 bits, increments every clk and wraps 255->0; one period = 256 clocks.
  - The cycle with cnt==255 is the "boundary".
  - period_tick = (cnt==0), registered.
- States and boundary transitions: OFF, FADE_IN, RUN, FADE_OUT. All state and g updates happen only at a boundary; enable and gain_target are sampled only there.
  - Let T = min(gain_target, 16).
  - OFF: if enable, go to FADE_IN; g stays 0.
  - FADE_IN:
    - if !enable, go to FADE_OUT;
    - else if g<T, g+1;
    - else if g>T, g-1;
    - go to RUN at the boundary where g_next==T.
  - RUN:
    - if !enable, go to FADE_OUT;
    - else g steps one unit toward T per boundary (tracks target changes); state stays RUN.
  - FADE_OUT:
    - if enable, go to FADE_IN with no g change this boundary;
    - else g-1 (saturating at 0);
    - go to OFF at the boundary where g_next==0.
- Duty computation at each boundary, using g_next (the value after this boundary's update):
  - s = {1'b0, wave_in} - 128 as signed 9-bit, range -128..127.
  - p = s * g_next as signed 14-bit.
  - q = p >>> 4 (arithmetic shift, floor).
  - duty_next = 128 + q, always within 0..255; no saturation is needed.
  - duty register loads duty_next. It is held constant for the whole following period and is never updated mid-period.
- PWM output:
  - pwm_out(k+1) = (state_k != OFF) && (cnt_k < duty_k), i.e. one clock of latency relative to cnt.
  - Exactly duty high clocks per period; duty=0 gives constant low, duty=255 gives 255/256 high.
  - g=0 in FADE_IN/FADE_OUT gives duty=128 (50%, midscale).
  - OFF forces pwm_out=0. duty still loads (128 when g=0) but is not used.
- Outputs: active = (state != OFF); gain_cur = g.
- Boundary cases:
  - gain_target=0 with enable=1: OFF -> FADE_IN -> RUN at the next boundary, with duty 128.
  - enable toggled within one period: only the value at the boundary matters.
  - wave_in changes mid-period: no effect until the next boundary.

Test Plan:
- Reset, then enable=1, gain_target=16, wave_in=200 constant -> FADE_IN at boundary b0; g=1..16 at b1..b16; RUN at b16; the period after b16 has exactly 200 high clocks; active=1.
- RUN at g=16, wave_in=255 -> 255 high / 1 low per period. wave_in=0 -> duty=0, pwm_out constantly 0. wave_in=128 -> duty 128.
- RUN, gain_target=8, wave_in=0 -> g steps 16->8 over 8 boundaries; then duty = 128 + ((-128*8)>>>4) = 64, with 64 high clocks per period. gain_target=20 -> clamps, g settles at 16.
- RUN at g=16, drop enable -> FADE_OUT; g 15..0 over 16 boundaries with duty moving toward 128; OFF at the boundary where g=0; then pwm_out=0 and active=0.
- FADE_OUT at g=5, re-assert enable before the boundary -> FADE_IN with g=5 at that boundary, then g increments to T; no jump in duty.
- Assert reset mid-FADE_IN at g=7, cnt=100 -> next cycle cnt=0, g=0, state OFF, pwm_out=0, duty=0.

Source files
------------

// File: rtl/pwm_dac_out.sv
// Single-bit PWM output stage for an 8-bit midscale-centred sample stream.
// Gain around midscale ramps one step per 256-clock period so start/stop stays click-free.
module pwm_dac_out #(
  parameter int MAX_GAIN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] gain_target,
  input  logic [7:0] wave_in,
  output logic       pwm_out,
  output logic       period_tick,
  output logic [7:0] duty,
  output logic [4:0] gain_cur,
  output logic       active
);

  typedef enum logic [1:0] {OFF, FADE_IN, RUN, FADE_OUT} state_t;

  state_t             state, state_next;
  logic [7:0]         cnt;
  logic [4:0]         g, g_next, target;
  logic               boundary;
  logic signed [8:0]  s;
  logic signed [13:0] p, q, sum;
  logic [7:0]         duty_next;

  assign boundary = (cnt == 8'hff);
  assign target   = (gain_target > 5'(MAX_GAIN)) ? 5'(MAX_GAIN) : gain_target;

  // Next state and gain; only committed on the last clock of a period.
  always_comb begin
    state_next = state;
    g_next     = g;
    case (state)
      OFF: begin
        if (enable) state_next = FADE_IN;
      end
      FADE_IN, RUN: begin
        if (!enable) begin
          state_next = FADE_OUT;
        end else begin
          if (g < target)      g_next = g + 5'd1;
          else if (g > target) g_next = g - 5'd1;
          if (state == FADE_IN && g_next == target) state_next = RUN;
        end
      end
      FADE_OUT: begin
        if (enable) begin
          state_next = FADE_IN;
        end else begin
          if (g != 5'd0) g_next = g - 5'd1;
          if (g_next == 5'd0) state_next = OFF;
        end
      end
      default: state_next = OFF;
    endcase
  end

  // Scale the signed sample by g/16; the floor shift keeps the result inside 0..255.
  always_comb begin
    s         = $signed({1'b0, wave_in}) - 9'sd128;
    p         = $signed({{5{s[8]}}, s}) * $signed({9'd0, g_next});
    q         = p >>> 4;
    sum       = q + 14'sd128;
    duty_next = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OFF;
      g           <= 5'd0;
      cnt         <= 8'd0;
      duty        <= 8'd0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b1;  // cnt restarts at 0, so the tick is already due
    end else begin
      cnt         <= cnt + 8'd1;
      period_tick <= boundary;
      pwm_out     <= (state != OFF) && (cnt < duty);
      if (boundary) begin
        state <= state_next;
        g     <= g_next;
        duty  <= duty_next;
      end
    end
  end

  assign active   = (state != OFF);
  assign gain_cur = g;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out: directed scenarios plus randomized stimulus
// compared against an integer-arithmetic period-level model.
module tb_pwm_dac_out;

  localparam int S_OFF = 0, S_FIN = 1, S_RUN = 2, S_FOUT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] gain_target = 5'd0;
  logic [7:0] wave_in = 8'd0;
  logic       pwm_out, period_tick, active;
  logic [7:0] duty;
  logic [4:0] gain_cur;

  int passed = 0;
  int total  = 0;

  int m_cnt = 0, m_state = S_OFF, m_g = 0, m_duty = 0, m_pwm = 0, m_tick = 1;

  pwm_dac_out #(.MAX_GAIN(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gain_target(gain_target),
    .wave_in(wave_in), .pwm_out(pwm_out), .period_tick(period_tick),
    .duty(duty), .gain_cur(gain_cur), .active(active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int floor_div16(int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic void model_boundary();
    int t;
    t = (int'(gain_target) > 16) ? 16 : int'(gain_target);
    case (m_state)
      S_OFF:  if (enable) m_state = S_FIN;
      S_FIN, S_RUN: begin
        if (!enable) m_state = S_FOUT;
        else begin
          if (m_g < t) m_g++;
          else if (m_g > t) m_g--;
          if (m_state == S_FIN && m_g == t) m_state = S_RUN;
        end
      end
      default: begin
        if (enable) m_state = S_FIN;
        else begin
          if (m_g > 0) m_g--;
          if (m_g == 0) m_state = S_OFF;
        end
      end
    endcase
    m_duty = 128 + floor_div16((int'(wave_in) - 128) * m_g);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_state = S_OFF; m_g = 0; m_duty = 0; m_pwm = 0; m_tick = 1;
    end else begin
      m_pwm = (m_state != S_OFF && m_cnt < m_duty) ? 1 : 0;
      if (m_cnt == 255) model_boundary();
      m_cnt  = (m_cnt + 1) % 256;
      m_tick = (m_cnt == 0) ? 1 : 0;
    end
    #1;
  endtask

  task automatic next_boundary();
    tick();
    for (int i = 0; i < 300 && m_cnt != 0; i++) tick();
  endtask

  task automatic count_period(output int highs);
    highs = 0;
    repeat (256) begin
      tick();
      highs += int'(pwm_out);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    enable = 1'b0; gain_target = 5'd0; wave_in = 8'd0;
    do_reset();
    total++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %0b want 0", pwm_out); else passed++;
    total++; if (duty !== 8'd0) $display("FAIL reset_duty got %0d want 0", duty); else passed++;
    total++; if (gain_cur !== 5'd0) $display("FAIL reset_gain got %0d want 0", gain_cur); else passed++;
    total++; if (active !== 1'b0) $display("FAIL reset_active got %0b want 0", active); else passed++;
    total++; if (period_tick !== 1'b1) $display("FAIL reset_tick got %0b want 1", period_tick); else passed++;
  endtask

  task automatic test_period_tick();
    int bad_tick = 0, bad_pwm = 0, ticks = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (period_tick !== 1'(m_tick)) bad_tick++;
      if (pwm_out !== 1'b0) bad_pwm++;
      ticks += int'(period_tick);
    end
    total++; if (bad_tick != 0) $display("FAIL tick_align got %0d bad cycles want 0", bad_tick); else passed++;
    total++; if (ticks != 2) $display("FAIL tick_count got %0d want 2", ticks); else passed++;
    total++; if (bad_pwm != 0) $display("FAIL off_pwm got %0d high cycles want 0", bad_pwm); else passed++;
  endtask

  task automatic test_fade_in();
    int highs;
    do_reset();
    enable = 1'b1; gain_target = 5'd16; wave_in = 8'd200;
    next_boundary();
    total++; if (active !== 1'b1) $display("FAIL fadein_active got %0b want 1", active); else passed++;
    total++; if (duty !== 8'd128) $display("FAIL fadein_b0_duty got %0d want 128", duty); else passed++;
    for (int i = 1; i <= 16; i++) begin
      next_boundary();
      total++; if (gain_cur !== 5'(i)) $display("FAIL fadein_gain got %0d want %0d", gain_cur, i); else passed++;
      total++; if (duty !== 8'(m_duty)) $display("FAIL fadein_duty got %0d want %0d", duty, m_duty); else passed++;
    end
    count_period(highs);
    total++; if (highs != 200) $display("FAIL fadein_highs got %0d want 200", highs); else passed++;
  endtask

  task automatic test_full_scale();
    int highs;
    wave_in = 8'd255;
    next_boundary();
    total++; if (duty !== 8'd255) $display("FAIL full_duty got %0d want 255", duty); else passed++;
    count_period(highs);
    total++; if (highs != 255) $display("FAIL full_highs got %0d want 255", highs); else passed++;
    wave_in = 8'd0;
    next_boundary();
    total++; if (duty !== 8'd0) $display("FAIL zero_duty got %0d want 0", duty); else passed++;
    repeat (100) tick();
    wave_in = 8'd128;
    tick();
    total++; if (duty !== 8'd0) $display("FAIL midperiod_duty got %0d want 0", duty); else passed++;
    next_boundary();
    count_period(highs);
    total++; if (highs != 128) $display("FAIL mid_highs got %0d want 128", highs); else passed++;
  endtask

  task automatic test_gain_track();
    int highs;
    gain_target = 5'd8; wave_in = 8'd0;
    for (int i = 15; i >= 8; i--) begin
      next_boundary();
      total++; if (gain_cur !== 5'(i)) $display("FAIL track_down got %0d want %0d", gain_cur, i); else passed++;
    end
    total++; if (duty !== 8'd64) $display("FAIL track_duty got %0d want 64", duty); else passed++;
    count_period(highs);
    total++; if (highs != 64) $display("FAIL track_highs got %0d want 64", highs); else passed++;
    gain_target = 5'd20;
    for (int i = 9; i <= 16; i++) next_boundary();
    next_boundary();
    total++; if (gain_cur !== 5'd16) $display("FAIL clamp_gain got %0d want 16", gain_cur); else passed++;
    total++; if (duty !== 8'd0) $display("FAIL clamp_duty got %0d want 0", duty); else passed++;
  endtask

  task automatic test_fade_out();
    int highs;
    wave_in = 8'd200; enable = 1'b0;
    next_boundary();
    total++; if (gain_cur !== 5'd16) $display("FAIL fadeout_first got %0d want 16", gain_cur); else passed++;
    for (int i = 15; i >= 0; i--) begin
      next_boundary();
      total++; if (gain_cur !== 5'(i)) $display("FAIL fadeout_gain got %0d want %0d", gain_cur, i); else passed++;
      total++; if (duty !== 8'(m_duty)) $display("FAIL fadeout_duty got %0d want %0d", duty, m_duty); else passed++;
    end
    total++; if (active !== 1'b0) $display("FAIL fadeout_active got %0b want 0", active); else passed++;
    total++; if (duty !== 8'd128) $display("FAIL fadeout_end_duty got %0d want 128", duty); else passed++;
    count_period(highs);
    total++; if (highs != 0) $display("FAIL off_highs got %0d want 0", highs); else passed++;
  endtask

  task automatic test_reenable();
    enable = 1'b1; gain_target = 5'd16; wave_in = 8'd200;
    repeat (6) next_boundary();
    total++; if (gain_cur !== 5'd5) $display("FAIL reen_g5 got %0d want 5", gain_cur); else passed++;
    enable = 1'b0;
    next_boundary();
    total++; if (duty !== 8'd150) $display("FAIL reen_fout_duty got %0d want 150", duty); else passed++;
    repeat (50) tick();
    enable = 1'b1;
    repeat (50) tick();
    enable = 1'b0;
    repeat (50) tick();
    enable = 1'b1;
    next_boundary();
    total++; if (gain_cur !== 5'd5) $display("FAIL reen_hold got %0d want 5", gain_cur); else passed++;
    total++; if (duty !== 8'd150) $display("FAIL reen_duty got %0d want 150", duty); else passed++;
    total++; if (active !== 1'b1) $display("FAIL reen_active got %0b want 1", active); else passed++;
    next_boundary();
    total++; if (gain_cur !== 5'd6) $display("FAIL reen_step got %0d want 6", gain_cur); else passed++;
  endtask

  task automatic test_zero_gain();
    int highs;
    do_reset();
    enable = 1'b1; gain_target = 5'd0; wave_in = 8'($urandom_range(0, 255));
    next_boundary();
    total++; if (duty !== 8'd128) $display("FAIL zg_b0_duty got %0d want 128", duty); else passed++;
    next_boundary();
    total++; if (gain_cur !== 5'd0) $display("FAIL zg_gain got %0d want 0", gain_cur); else passed++;
    count_period(highs);
    total++; if (highs != 128) $display("FAIL zg_highs got %0d want 128", highs); else passed++;
  endtask

  task automatic test_reset_mid_fade();
    do_reset();
    enable = 1'b1; gain_target = 5'd16; wave_in = 8'd200;
    repeat (8) next_boundary();
    repeat (100) tick();
    total++; if (gain_cur !== 5'd7) $display("FAIL rmid_pre got %0d want 7", gain_cur); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (gain_cur !== 5'd0) $display("FAIL rmid_gain got %0d want 0", gain_cur); else passed++;
    total++; if (duty !== 8'd0) $display("FAIL rmid_duty got %0d want 0", duty); else passed++;
    total++; if (active !== 1'b0) $display("FAIL rmid_active got %0b want 0", active); else passed++;
    total++; if (pwm_out !== 1'b0) $display("FAIL rmid_pwm got %0b want 0", pwm_out); else passed++;
    total++; if (period_tick !== 1'b1) $display("FAIL rmid_tick got %0b want 1", period_tick); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 40 * 256; c++) begin
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      if ($urandom_range(0, 699) == 0) gain_target = 5'($urandom_range(0, 31));
      wave_in = 8'($urandom_range(0, 255));
      reset   = ($urandom_range(0, 3999) == 0);
      tick();
      total++; if (pwm_out !== 1'(m_pwm)) $display("FAIL rnd_pwm c=%0d got %0b want %0d", c, pwm_out, m_pwm); else passed++;
      total++; if (duty !== 8'(m_duty)) $display("FAIL rnd_duty c=%0d got %0d want %0d", c, duty, m_duty); else passed++;
      total++; if (gain_cur !== 5'(m_g)) $display("FAIL rnd_gain c=%0d got %0d want %0d", c, gain_cur, m_g); else passed++;
      total++; if (active !== (m_state != S_OFF)) $display("FAIL rnd_active c=%0d got %0b want %0d", c, active, m_state != S_OFF); else passed++;
      total++; if (period_tick !== 1'(m_tick)) $display("FAIL rnd_tick c=%0d got %0b want %0d", c, period_tick, m_tick); else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period_tick();
    test_fade_in();
    test_full_scale();
    test_gain_track();
    test_fade_out();
    test_reenable();
    test_zero_gain();
    test_reset_mid_fade();
    enable = 1'b1; gain_target = 5'd12;
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
